// File: rtl/mini_aes_key_sched.sv
// Mini-AES key expansion sequencer: derives round keys K1/K2 from the cipher key
// using two lookups on a shared, arbitrated, registered NibbleSub unit.
module mini_aes_key_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] key,
    output logic        ks_req,
    input  logic        ks_gnt,
    output logic        sbox_en,
    output logic [3:0]  sbox_a,
    input  logic [3:0]  sbox_b,
    input  logic        sbox_valid,
    output logic        busy,
    output logic        done,
    output logic        key_valid,
    output logic [15:0] rk0,
    output logic [15:0] rk1,
    output logic [15:0] rk2
);

    typedef enum logic [2:0] {
        StIdle,
        StSub1,
        StWait1,
        StSub2,
        StWait2,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] rk0_q, rk1_q, rk2_q;
    logic        key_valid_q;

    // One round of the word recurrence: first word mixes in S-box output and round constant,
    // each following word chains off the one just produced.
    function automatic logic [15:0] expand(input logic [15:0] prev, input logic [3:0] sub,
                                           input logic [3:0] rcon);
        logic [3:0] wa, wb, wc, wd;
        wa = prev[15:12] ^ sub ^ rcon;
        wb = prev[11:8] ^ wa;
        wc = prev[7:4] ^ wb;
        wd = prev[3:0] ^ wc;
        return {wa, wb, wc, wd};
    endfunction

    always_comb begin
        state_d = state_q;
        ks_req  = 1'b0;
        sbox_en = 1'b0;
        sbox_a  = 4'h0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StSub1;
            end
            StSub1: begin
                ks_req = 1'b1;
                if (ks_gnt) begin
                    sbox_en = 1'b1;
                    sbox_a  = rk0_q[3:0];
                    state_d = StWait1;
                end
            end
            StWait1: begin
                ks_req = 1'b1;
                if (sbox_valid) state_d = StSub2;
            end
            StSub2: begin
                ks_req = 1'b1;
                if (ks_gnt) begin
                    sbox_en = 1'b1;
                    sbox_a  = rk1_q[3:0];
                    state_d = StWait2;
                end
            end
            StWait2: begin
                ks_req = 1'b1;
                if (sbox_valid) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rk0_q       <= 16'h0000;
            rk1_q       <= 16'h0000;
            rk2_q       <= 16'h0000;
            key_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && start) begin
                rk0_q       <= key;
                key_valid_q <= 1'b0;
            end
            // The S-box output is zero while disabled, so only sample it when flagged valid.
            if (state_q == StWait1 && sbox_valid) rk1_q <= expand(rk0_q, sbox_b, 4'h1);
            if (state_q == StWait2 && sbox_valid) rk2_q <= expand(rk1_q, sbox_b, 4'h2);
            if (state_q == StDone) key_valid_q <= 1'b1;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign key_valid = key_valid_q;
    assign rk0       = rk0_q;
    assign rk1       = rk1_q;
    assign rk2       = rk2_q;

endmodule

// File: tb/tb_mini_aes_key_sched.sv
// Directed bench for mini_aes_key_sched with a behavioural registered Mini-AES S-box.
module tb_mini_aes_key_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] key;
    logic        ks_req;
    logic        ks_gnt;
    logic        sbox_en;
    logic [3:0]  sbox_a;
    logic [3:0]  sbox_b = 4'h0;
    logic        sbox_valid = 1'b0;
    logic        busy;
    logic        done;
    logic        key_valid;
    logic [15:0] rk0, rk1, rk2;

    int tests = 0;
    int fails = 0;
    int lat;

    always #5 clk = ~clk;

    mini_aes_key_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key       (key),
        .ks_req    (ks_req),
        .ks_gnt    (ks_gnt),
        .sbox_en   (sbox_en),
        .sbox_a    (sbox_a),
        .sbox_b    (sbox_b),
        .sbox_valid(sbox_valid),
        .busy      (busy),
        .done      (done),
        .key_valid (key_valid),
        .rk0       (rk0),
        .rk1       (rk1),
        .rk2       (rk2)
    );

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'hE;  4'h1: return 4'h4;  4'h2: return 4'hD;  4'h3: return 4'h1;
            4'h4: return 4'h2;  4'h5: return 4'hF;  4'h6: return 4'hB;  4'h7: return 4'h8;
            4'h8: return 4'h3;  4'h9: return 4'hA;  4'hA: return 4'h6;  4'hB: return 4'hC;
            4'hC: return 4'h5;  4'hD: return 4'h9;  4'hE: return 4'h0;  default: return 4'h7;
        endcase
    endfunction

    always @(posedge clk) begin
        sbox_valid <= sbox_en;
        sbox_b     <= sbox_en ? sbox(sbox_a) : 4'h0;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the cycle where start is asserted; returns cycles until done (bounded).
    task automatic run_to_done(output int n);
        n = 0;
        do begin
            step();
            start = 1'b0;
            n++;
            #1;
        end while (!done && n < 30);
        if (!done) chk("done_timeout", 16'(n), 16'd5);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        key    = 16'h0000;
        ks_gnt = 1'b1;
        step();
        step();
        #1;
        chk("rst_outs", {10'h0, ks_req, sbox_en, busy, done, key_valid, 1'b0}, 16'h0);
        chk("rst_sbox_a", {12'h0, sbox_a}, 16'h0);
        chk("rst_rk", rk0 | rk1 | rk2, 16'h0);
        rst_n = 1'b1;

        // Key C3F0, grant always: walk every cycle.
        key   = 16'hC3F0;
        start = 1'b1;
        #1;
        chk("c0_busy", {15'h0, busy}, 16'h0);
        step(); start = 1'b0; #1;
        chk("c1_req_en", {14'h0, ks_req, sbox_en}, 16'h3);
        chk("c1_sbox_a", {12'h0, sbox_a}, 16'h0);
        chk("c1_busy", {15'h0, busy}, 16'h1);
        step(); #1;
        chk("c2_req_en", {14'h0, ks_req, sbox_en}, 16'h2);
        chk("c2_rk0", rk0, 16'hC3F0);
        step(); #1;
        chk("c3_rk1", rk1, 16'h30FF);
        chk("c3_en", {15'h0, sbox_en}, 16'h1);
        chk("c3_sbox_a", {12'h0, sbox_a}, 16'hF);
        step(); #1;
        chk("c4_req_en", {14'h0, ks_req, sbox_en}, 16'h2);
        chk("c4_done", {15'h0, done}, 16'h0);
        step(); #1;
        chk("c5_done", {15'h0, done}, 16'h1);
        chk("c5_req", {15'h0, ks_req}, 16'h0);
        chk("c5_rk2", rk2, 16'h6696);
        chk("c5_kv", {15'h0, key_valid}, 16'h0);

        // Back-to-back start in cycle 6 with key 0000.
        step();
        key   = 16'h0000;
        start = 1'b1;
        #1;
        chk("c6_kv", {15'h0, key_valid}, 16'h1);
        chk("c6_done", {15'h0, done}, 16'h0);
        chk("c6_busy", {15'h0, busy}, 16'h0);
        step(); start = 1'b0; #1;
        chk("b2b_kv_low", {15'h0, key_valid}, 16'h0);
        chk("b2b_busy", {15'h0, busy}, 16'h1);
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            chk("b2b_kv_hold", {15'h0, key_valid}, 16'h0);
        end
        step(); #1;
        chk("b2b_done", {15'h0, done}, 16'h1);
        chk("z_rk0", rk0, 16'h0000);
        chk("z_rk1", rk1, 16'hFFFF);
        chk("z_rk2", rk2, 16'hA5A5);
        step(); #1;
        chk("b2b_kv_high", {15'h0, key_valid}, 16'h1);

        // Grant denied 3 cycles in SUB1 and 2 in SUB2.
        step();
        key   = 16'hC3F0;
        start = 1'b1;
        ks_gnt = 1'b0;
        step(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("deny1_req_en", {14'h0, ks_req, sbox_en}, 16'h2);
            step();
        end
        ks_gnt = 1'b1; #1;
        chk("gnt1_en", {15'h0, sbox_en}, 16'h1);
        step(); ks_gnt = 1'b0; #1;
        chk("stall_wait1", {14'h0, ks_req, sbox_en}, 16'h2);
        step();
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("deny2_req_en", {14'h0, ks_req, sbox_en}, 16'h2);
            step();
        end
        ks_gnt = 1'b1; #1;
        chk("gnt2_en_a", {11'h0, sbox_en, sbox_a}, 16'h1F);
        step(); #1;
        chk("stall_c9_done", {15'h0, done}, 16'h0);
        step(); #1;
        chk("stall_c10_done", {15'h0, done}, 16'h1);
        chk("stall_rk1", rk1, 16'h30FF);
        chk("stall_rk2", rk2, 16'h6696);

        // Start pulsed during WAIT1 is ignored.
        step();
        key   = 16'h1234;
        start = 1'b1;
        step(); start = 1'b0; #1;
        chk("ign_busy1", {15'h0, busy}, 16'h1);
        step(); key = 16'hFFFF; start = 1'b1; #1;
        chk("ign_busy2", {15'h0, busy}, 16'h1);
        step(); start = 1'b0; #1;
        chk("ign_busy3", {15'h0, busy}, 16'h1);
        step(); #1;
        chk("ign_busy4", {15'h0, busy}, 16'h1);
        step(); #1;
        chk("ign_done", {15'h0, done}, 16'h1);
        chk("ign_rk0", rk0, 16'h1234);
        chk("ign_rk1", rk1, 16'h2037);
        chk("ign_rk2", rk2, 16'h88BC);

        // Reset during WAIT2 aborts the expansion.
        step();
        key   = 16'hC3F0;
        start = 1'b1;
        step(); start = 1'b0;
        step();
        step();
        step(); rst_n = 1'b0; #1;
        chk("pre_rst_wait2", {14'h0, ks_req, sbox_en}, 16'h2);
        step(); rst_n = 1'b1; #1;
        chk("mid_rst_outs", {11'h0, ks_req, sbox_en, busy, done, key_valid}, 16'h0);
        chk("mid_rst_rk", rk0 | rk1 | rk2, 16'h0);
        step(); #1;
        chk("mid_rst_nodone", {15'h0, done}, 16'h0);

        // Fresh expansion after reset.
        key   = 16'h0000;
        start = 1'b1;
        run_to_done(lat);
        chk("post_rst_lat", 16'(lat), 16'd5);
        chk("post_rst_rk1", rk1, 16'hFFFF);
        chk("post_rst_rk2", rk2, 16'hA5A5);
        step(); #1;
        chk("post_rst_kv", {15'h0, key_valid}, 16'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
